gr_heep_ext_obi_rr_arbiter: RTL
===============================

// Module: gr_heep_ext_obi_rr_arbiter
// PURPOSE
// Parametrised N-to-1 OBI arbiter for the external OBI bus. Merges NMaster external masters onto one
// slave port using fair round-robin. Keeps address-phase stability (OBI lock) and tracks outstanding
// transactions in an ID FIFO, so each response returns in order to the master that issued it.
// PARAMETERS
// NMaster        2   number of external masters (>=1; 1 = pass-through with tracking)
// MaxOutstanding 4   max accepted-but-unanswered transactions (ID FIFO depth, >=1)
// AddrWidth      32  address width
// DataWidth      32  data width; BE width = DataWidth/8
// PORTS
// clk_i          in   1               clock
// rst_i          in   1               synchronous active-high reset
// m_req_i        in   NMaster         per-master request
// m_gnt_o        out  NMaster         per-master grant (one-hot or zero)
// m_addr_i       in   NMaster*AW      per-master address
// m_we_i         in   NMaster         per-master write enable
// m_be_i         in   NMaster*DW/8    per-master byte enable
// m_wdata_i      in   NMaster*DW      per-master write data
// m_rvalid_o     out  NMaster         per-master response valid (one-hot or zero)
// m_rdata_o      out  NMaster*DW      per-master read data (rdata broadcast; qualify with rvalid)
// s_req_o/s_gnt_i/s_addr_o/s_we_o/s_be_o/s_wdata_o  out/in/out/out/out/out  1/1/AW/1/DW/8/DW  slave addr phase
// s_rvalid_i     in   1               slave response valid
// s_rdata_i      in   DW              slave read data
// outstanding_o  out  clog2(MaxOut+1) current outstanding count
// err_o          out  1               sticky: s_rvalid_i seen with empty ID FIFO
// BEHAVIOUR
// - Reset (sync, rst_i=1 at posedge): rr pointer=0, lock=0, ID FIFO empty, outstanding_o=0, err_o=0;
//   all m_gnt_o, m_rvalid_o, s_req_o = 0 combinationally whenever FIFO empty and no m_req_i.
// - Selection: if lock=1, winner = locked index. Else winner = first requesting index at or after
//   rr pointer, wrapping modulo NMaster.
// - s_req_o = (any m_req_i) && (outstanding_o < MaxOutstanding). Slave addr/we/be/wdata = winner's.
// - Handshake: accept = s_req_o && s_gnt_i, same cycle m_gnt_o[winner]=s_gnt_i, zero latency
//   (purely combinational gnt path). On accept: push winner index into FIFO, rr pointer <=
//   (winner+1) mod NMaster, lock <= 0.
// - Lock: if s_req_o=1 and s_gnt_i=0, lock <= 1 with the current winner, so the address phase stays
//   stable until granted. Masters obey OBI (req held until gnt). Higher-priority req arriving while
//   locked does not preempt.
// - FIFO full (outstanding_o==MaxOutstanding): s_req_o=0, no m_gnt_o, even if s_rvalid_i pops in the
//   same cycle. Req is re-enabled the next cycle. Lock is kept while full.
// - Response: on s_rvalid_i with FIFO non-empty, m_rvalid_o[head]=1, pop head (same cycle,
//   combinational). Responses are in order; slave returns exactly one rvalid per accept, >=1 cycle later.
// - Simultaneous accept and pop (not full): count unchanged, pointers both advance.
// - s_rvalid_i with FIFO empty: no m_rvalid_o, err_o <= 1 (sticky until reset).
// - Reset mid-transaction: FIFO flushed; late s_rvalid_i after reset sets err_o.
// - NMaster==1: rr pointer constant 0; lock/FIFO still active.
// TESTING
// 1 Reset: rst_i=1 2 cycles with m_req_i=2'b11 -> s_req_o live only after reset; outstanding_o=0, err_o=0.
// 2 Round-robin: NMaster=2, both req held, s_gnt_i=1 always, rvalid 1 cycle later ->
//   grants alternate m0,m1,m0,m1; m_rvalid_o follows same order.
// 3 Lock: m0 req, s_gnt_i=0 for 3 cycles, m1 req from cycle 1 -> s_addr_o stays m0's addr; m0 granted
//   in cycle 3; next grant goes to m1.
// 4 Full: MaxOutstanding=4, 4 accepts, no rvalid -> 5th req: s_req_o=0. One s_rvalid_i -> next cycle
//   s_req_o=1. outstanding_o goes 4->3->4.
// 5 Simultaneous: accept m1 and rvalid for pending m0 in the same cycle -> m_rvalid_o=2'b01,
//   m_gnt_o=2'b10, count unchanged.
// 6 Spurious: s_rvalid_i=1 with empty FIFO -> m_rvalid_o=0, err_o=1 and held until rst_i.

Source files
------------

// File: rtl/gr_heep_ext_obi_rr_arbiter.sv
// N-to-1 round-robin OBI arbiter for the external bus.
// Address phase is locked until granted; an ID FIFO routes in-order responses.
module gr_heep_ext_obi_rr_arbiter #(
  parameter int unsigned NMaster        = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  localparam int unsigned BeWidth = DataWidth / 8,
  localparam int unsigned IdW     = (NMaster > 1) ? $clog2(NMaster) : 1,
  localparam int unsigned PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1,
  localparam int unsigned CntW    = $clog2(MaxOutstanding + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NMaster-1:0]           m_req_i,
  output logic [NMaster-1:0]           m_gnt_o,
  input  logic [NMaster*AddrWidth-1:0] m_addr_i,
  input  logic [NMaster-1:0]           m_we_i,
  input  logic [NMaster*BeWidth-1:0]   m_be_i,
  input  logic [NMaster*DataWidth-1:0] m_wdata_i,
  output logic [NMaster-1:0]           m_rvalid_o,
  output logic [NMaster*DataWidth-1:0] m_rdata_o,
  output logic                         s_req_o,
  input  logic                         s_gnt_i,
  output logic [AddrWidth-1:0]         s_addr_o,
  output logic                         s_we_o,
  output logic [BeWidth-1:0]           s_be_o,
  output logic [DataWidth-1:0]         s_wdata_o,
  input  logic                         s_rvalid_i,
  input  logic [DataWidth-1:0]         s_rdata_i,
  output logic [CntW-1:0]              outstanding_o,
  output logic                         err_o
);

  localparam int NM = int'(NMaster);

  logic [IdW-1:0]  r_rr;
  logic            r_lock;
  logic [IdW-1:0]  r_lock_idx;
  logic [IdW-1:0]  r_fifo [MaxOutstanding];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_cnt;
  logic            r_err;

  logic [IdW-1:0]  w_rr_win;
  logic [IdW-1:0]  w_win;
  logic [IdW-1:0]  w_head;
  logic [IdW-1:0]  w_rr_nxt;
  logic            w_full;
  logic            w_empty;
  logic            w_accept;
  logic            w_stall;
  logic            w_pop;
  int              w_best;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Pick the requester at the smallest forward distance from the rr pointer.
  always_comb begin
    w_rr_win = r_rr;
    w_best   = NM;
    for (int j = 0; j < NM; j++) begin
      if (m_req_i[j] && ((j + NM - int'(r_rr)) % NM) < w_best) begin
        w_best   = (j + NM - int'(r_rr)) % NM;
        w_rr_win = IdW'(j);
      end
    end
  end

  assign w_win    = r_lock ? r_lock_idx : w_rr_win;
  assign w_full   = (r_cnt == CntW'(MaxOutstanding));
  assign w_empty  = (r_cnt == '0);
  // Nothing is offered or routed while reset is held, so the FIFO
  // never misses a transaction the slave thinks it accepted.
  assign s_req_o  = !rst_i && (|m_req_i) && !w_full;
  assign w_accept = s_req_o && s_gnt_i;
  assign w_stall  = s_req_o && !s_gnt_i;
  assign w_pop    = !rst_i && s_rvalid_i && !w_empty;
  assign w_head   = r_fifo[r_rptr];
  assign w_rr_nxt = (w_win == IdW'(NMaster - 1)) ? '0 : w_win + IdW'(1);

  assign m_rdata_o     = {NMaster{s_rdata_i}};
  assign outstanding_o = r_cnt;
  assign err_o         = r_err;

  // Route the winner's address phase to the slave and steer gnt/rvalid.
  always_comb begin
    s_addr_o   = '0;
    s_we_o     = 1'b0;
    s_be_o     = '0;
    s_wdata_o  = '0;
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    for (int j = 0; j < NM; j++) begin
      if (w_win == IdW'(j)) begin
        s_addr_o  = m_addr_i[j*AddrWidth +: AddrWidth];
        s_we_o    = m_we_i[j];
        s_be_o    = m_be_i[j*BeWidth +: BeWidth];
        s_wdata_o = m_wdata_i[j*DataWidth +: DataWidth];
      end
      m_gnt_o[j]    = w_accept && (w_win == IdW'(j));
      m_rvalid_o[j] = w_pop && (w_head == IdW'(j));
    end
  end

  // Arbitration state, lock, FIFO pointers, count and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr       <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rr   <= w_rr_nxt;
        r_lock <= 1'b0;
        r_wptr <= ptr_inc(r_wptr);
      end else if (w_stall) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_win;
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      r_cnt <= r_cnt + CntW'(w_accept) - CntW'(w_pop);
      if (s_rvalid_i && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  // ID storage: the owner of each accepted transaction, in issue order.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_fifo[r_wptr] <= w_win;
    end
  end

endmodule
